stbus_rx_deser: RTL



---
 rtl/stbus_rx_deser.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stbus_rx_deser.sv
// ST-bus serial receive deserializer: F0 frame alignment (HUNT/SYNC/LOCKED), byte recovery, selected-channel capture.
// Optional STBUS_RX_ERRCNT_EN adds a saturating err_cnt output cleared by wr with wdata[7]=1.
module stbus_rx_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       f0,
  input  logic       sti,
  input  logic [7:0] wdata,
  input  logic       wr,
  output logic [7:0] rx_data,
  output logic [4:0] rx_ch,
  output logic       rx_valid,
  output logic [7:0] sel_data,
  output logic       sel_stb,
  output logic       locked,
  output logic       frame_err
`ifdef STBUS_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic       missed, missed_nxt;
  logic       f0_d, fp;
  logic       err_nxt, miss_evt;
  logic [6:0] sr;
  logic [4:0] sel_ch;
  logic [7:0] byte_val;
  logic       emit, sel_hit;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 9'd1;
    missed_nxt = missed;
    err_nxt    = 1'b0;
    miss_evt   = 1'b0;
    case (state)
      HUNT: begin
        cnt_nxt    = '0;
        missed_nxt = 1'b0;
        if (fp) state_nxt = SYNC;
      end
      SYNC: begin
        if (fp) begin
          missed_nxt = 1'b0;
          if (cnt == 9'd511) state_nxt = LOCKED;
          else               err_nxt   = 1'b1;
        end
      end
      LOCKED: begin
        if (fp) begin
          missed_nxt = 1'b0;
          if (cnt != 9'd511) begin
            state_nxt = SYNC;
            err_nxt   = 1'b1;
          end
        end else if (cnt == 9'd511) begin
          miss_evt = 1'b1;
          if (missed) begin
            state_nxt  = HUNT;
            cnt_nxt    = '0;
            missed_nxt = 1'b0;
          end else begin
            missed_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
    // any frame pulse realigns the counter regardless of state
    if (fp) cnt_nxt = '0;
  end

  // validity follows the state being entered, so rx_valid never appears without locked
  assign byte_val = {sr, sti};
  assign emit     = (cnt[3:0] == 4'hF) && (state_nxt == LOCKED);
  assign sel_hit  = (cnt[8:4] == sel_ch);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      cnt       <= '0;
      missed    <= 1'b0;
      f0_d      <= 1'b1;
      fp        <= 1'b0;
      sr        <= '0;
      sel_ch    <= '0;
      rx_data   <= '0;
      rx_ch     <= '0;
      rx_valid  <= 1'b0;
      sel_data  <= '0;
      sel_stb   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      f0_d      <= f0;
      fp        <= f0_d & ~f0;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      missed    <= missed_nxt;
      frame_err <= err_nxt;
      if (cnt[0]) sr <= byte_val[6:0];
      rx_valid <= emit;
      sel_stb  <= emit && sel_hit;
      if (emit) begin
        rx_data <= byte_val;
        rx_ch   <= cnt[8:4];
        if (sel_hit) sel_data <= byte_val;
      end
      if (wr) sel_ch <= wdata[4:0];
    end
  end

`ifdef STBUS_RX_ERRCNT_EN
  logic unused_wdata;
  assign unused_wdata = ^wdata[6:5];

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (wr && wdata[7]) begin
      err_cnt <= '0;
    end else if ((err_nxt || miss_evt) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata[7:5];
`endif

endmodule
